data_cache_ctrl: RTL

DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

---
 rtl/data_cache_ctrl_pkg.sv | 15 +
 rtl/cache_line_array.sv | 45 ++++
 rtl/data_cache_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/data_cache_ctrl_pkg.sv
// Shared definitions for the data cache controller: geometry defaults and FSM encoding.
package data_cache_ctrl_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int INDEX_W_DEF = 5;
    localparam int DATA_W_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2,
        DONE    = 2'd3
    } cache_state_e;

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped line storage: async read, sync write, valid bits cleared by async reset.
module cache_line_array #(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data carry no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/data_cache_ctrl.sv
// Write-through, no-write-allocate, direct-mapped one-word-per-line data cache controller.
// Handshake: stall=1 freezes the CPU with its request held; mem_read/mem_write stay high until a mem_ready strobe.
module data_cache_ctrl
    import data_cache_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output cache_state_e      state_dbg
);

    localparam int TAG_W = ADDR_W - INDEX_W;

    cache_state_e state_q, state_d;
    logic [DATA_W-1:0] rdata_q;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [DATA_W-1:0]  line_data;
    logic               hit;
    logic               line_we;
    logic [DATA_W-1:0]  line_wdata;
    logic               stall_c, mem_read_c, mem_write_c;
    logic [DATA_W-1:0]  rdata_c;

    assign index = cpu_addr[INDEX_W-1:0];
    assign tag   = cpu_addr[ADDR_W-1:INDEX_W];
    assign hit   = line_valid && (line_tag == tag);

    cache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_lines (
        .clk      (clk),
        .reset    (reset),
        .rd_index (index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .we       (line_we),
        .wr_index (index),
        .wr_tag   (tag),
        .wr_data  (line_wdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RD_MISS && mem_ready) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        stall_c     = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        line_we     = 1'b0;
        line_wdata  = cpu_wdata;
        rdata_c     = '0;
        case (state_q)
            IDLE: begin
                // A write wins over a simultaneous read.
                if (cpu_write) begin
                    stall_c = 1'b1;
                    state_d = WR_THRU;
                end else if (cpu_read) begin
                    if (hit) begin
                        rdata_c = line_data;
                    end else begin
                        stall_c = 1'b1;
                        state_d = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                stall_c    = 1'b1;
                mem_read_c = 1'b1;
                mem_addr   = cpu_addr;
                if (mem_ready) begin
                    line_we    = 1'b1;
                    line_wdata = mem_rdata;
                    state_d    = DONE;
                end
            end
            WR_THRU: begin
                stall_c     = 1'b1;
                mem_write_c = 1'b1;
                mem_addr    = cpu_addr;
                mem_wdata   = cpu_wdata;
                if (mem_ready) begin
                    line_we = hit;
                    state_d = DONE;
                end
            end
            DONE: begin
                rdata_c = rdata_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset must silence the CPU-facing and memory strobes even while a request is presented.
    assign stall     = stall_c & reset;
    assign mem_read  = mem_read_c & reset;
    assign mem_write = mem_write_c & reset;
    assign cpu_rdata = reset ? rdata_c : '0;
    assign state_dbg = state_q;

endmodule
